median_sort_ctrl: RTL and testbench

- Sequencing controller for the 3x3 median-filter sort tree: three cascaded sort stages of 1 cycle each, LAT=3 total.
- Tracks frame/line/pixel position from the incoming video timing and drives the shared sort-stage enable.
- Delay-matches sync, valid, border flag and centre pixel to the sort-tree latency.
- Muxes the final output: raw centre pixel on image borders, median elsewhere. Reports frame completion and timing errors.

---
 rtl/median_sort_ctrl_if.sv | 31 +++
 rtl/median_sort_ctrl.sv | 148 ++++++++++++++
 tb/tb_median_sort_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/median_sort_ctrl_if.sv
// Video timing in, filtered pixel stream out, for the median sort controller.
// The slave side is the controller; the master side is the surrounding pipeline.
interface median_sort_ctrl_if #(
  parameter int DW = 10
);
  logic          per_vsync;
  logic          per_href;
  logic          per_clken;
  logic [DW-1:0] center_in;
  logic [DW-1:0] median_in;
  logic          sort_en;
  logic          post_vsync;
  logic          post_href;
  logic          post_clken;
  logic [DW-1:0] post_data;
  logic          frame_done;
  logic          line_err;
  logic          frame_err;

  modport master (
    output per_vsync, per_href, per_clken, center_in, median_in,
    input  sort_en, post_vsync, post_href, post_clken, post_data,
           frame_done, line_err, frame_err
  );

  modport slave (
    input  per_vsync, per_href, per_clken, center_in, median_in,
    output sort_en, post_vsync, post_href, post_clken, post_data,
           frame_done, line_err, frame_err
  );
endinterface

// File: rtl/median_sort_ctrl.sv
// Sequencing controller for the 3x3 median sort tree: tracks pixel position,
// enables the tree, delay-matches side-band data and selects border/median output.
module median_sort_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int LAT   = 3,
  parameter int DW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  median_sort_ctrl_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(LAT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FRAME, FLUSH, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [FW-1:0]   flush_cnt;
  logic            vsync_q;
  logic            href_q;
  logic            sort_en;
  logic            frame_done;
  logic            line_err;
  logic            frame_err;

  logic            vs_rise;
  logic            href_fall;
  logic            acc;
  logic            border;

  logic [LAT-1:0]    vs_d;
  logic [LAT-1:0]    href_d;
  logic [LAT-1:0]    acc_d;
  logic [LAT-1:0]    border_d;
  logic [LAT*DW-1:0] center_d;

  assign vs_rise   = bus.per_vsync & ~vsync_q;
  assign href_fall = href_q & ~bus.per_href;
  assign acc       = bus.per_href & bus.per_clken & (state == FRAME);
  assign border    = (col == '0) | (col == COL_LAST) | (row == '0) | (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      flush_cnt  <= '0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      sort_en    <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vsync_q    <= bus.per_vsync;
      href_q     <= bus.per_href;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise) begin
            col       <= '0;
            row       <= '0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            sort_en   <= 1'b1;
            state     <= FRAME;
          end
        end
        FRAME: begin
          // A restarted frame keeps the tree running; only the position resets.
          if (vs_rise) begin
            frame_err <= 1'b1;
            col       <= '0;
            row       <= '0;
          end else if (acc) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                flush_cnt <= FW'(LAT);
                state     <= FLUSH;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end else if (href_fall && (col != '0)) begin
            // Short line: realign to the next line, row saturating at the last.
            line_err <= 1'b1;
            col      <= '0;
            if (row != ROW_LAST) begin
              row <= row + RW'(1);
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - FW'(1);
          if (flush_cnt == FW'(1)) begin
            sort_en    <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          sort_en <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Shift-left delay lines: bit 0 takes the new sample, bit LAT-1 is the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= '0;
      href_d   <= '0;
      acc_d    <= '0;
      border_d <= '0;
      center_d <= '0;
    end else begin
      vs_d     <= (vs_d << 1) | LAT'(bus.per_vsync);
      href_d   <= (href_d << 1) | LAT'(bus.per_href);
      acc_d    <= (acc_d << 1) | LAT'(acc);
      border_d <= (border_d << 1) | LAT'(acc & border);
      center_d <= (center_d << DW) | (LAT*DW)'(bus.center_in);
    end
  end

  assign bus.sort_en    = sort_en;
  assign bus.frame_done = frame_done;
  assign bus.line_err   = line_err;
  assign bus.frame_err  = frame_err;
  assign bus.post_vsync = vs_d[LAT-1];
  assign bus.post_href  = href_d[LAT-1];
  assign bus.post_clken = acc_d[LAT-1];
  assign bus.post_data  = acc_d[LAT-1]
                        ? (border_d[LAT-1] ? center_d[LAT*DW-1 -: DW] : bus.median_in)
                        : '0;
endmodule

// File: tb/tb_median_sort_ctrl.sv
// Directed bench for median_sort_ctrl: a 4x3/LAT=3 instance and a 3x3/LAT=1 instance.
module tb_median_sort_ctrl;
  localparam logic [9:0] CTR = 10'h055;
  localparam logic [9:0] MED = 10'h100;

  typedef struct {
    logic       dut;
    int         cyc;
    logic [9:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vs    = 1'b0;
  logic href  = 1'b0;
  logic clken = 1'b0;
  logic sel   = 1'b0;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  int   done_cnt[2]   = '{0, 0};
  int   done_cyc[2]   = '{0, 0};
  int   exp_done[2]   = '{0, 0};
  int   pulse_cnt[2]  = '{0, 0};
  int   pulse_base[2] = '{0, 0};
  exp_t q[$];

  median_sort_ctrl_if #(.DW(10)) b0 ();
  median_sort_ctrl_if #(.DW(10)) b1 ();

  assign b0.per_vsync = vs & ~sel;
  assign b0.per_href  = href & ~sel;
  assign b0.per_clken = clken & ~sel;
  assign b0.center_in = CTR;
  assign b0.median_in = MED;
  assign b1.per_vsync = vs & sel;
  assign b1.per_href  = href & sel;
  assign b1.per_clken = clken & sel;
  assign b1.center_in = CTR;
  assign b1.median_in = MED;

  median_sort_ctrl #(.IMG_W(4), .IMG_H(3), .LAT(3), .DW(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  median_sort_ctrl #(.IMG_W(3), .IMG_H(3), .LAT(1), .DW(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int lat_of();
    return sel ? 1 : 3;
  endfunction

  function automatic logic [9:0] exp_pix(input int r, input int c);
    int w;
    w = sel ? 3 : 4;
    if (r == 0 || r == 2 || c == 0 || c == w - 1) return CTR;
    return MED;
  endfunction

  function automatic logic sort_en_s();    return sel ? b1.sort_en    : b0.sort_en;    endfunction
  function automatic logic post_vsync_s(); return sel ? b1.post_vsync : b0.post_vsync; endfunction
  function automatic logic post_clken_s(); return sel ? b1.post_clken : b0.post_clken; endfunction
  function automatic logic line_err_s();   return sel ? b1.line_err   : b0.line_err;   endfunction
  function automatic logic frame_err_s();  return sel ? b1.frame_err  : b0.frame_err;  endfunction

  task automatic mon(input logic s, input logic pc, input logic [9:0] pd, input logic fd);
    logic due;
    due = 1'b0;
    if (q.size() > 0) begin
      if (q[0].dut == s && q[0].cyc == cyc) due = 1'b1;
    end
    if (pc || due) begin
      check("post_clken", 32'(pc), 32'(due));
      if (due) begin
        if (pc) check("post_data", 32'(pd), 32'(q[0].data));
        void'(q.pop_front());
      end
    end
    if (pc) pulse_cnt[s]++;
    if (fd) begin
      done_cnt[s]++;
      done_cyc[s] = cyc;
    end
  endtask

  // Drive just after the rising edge, observe on the falling edge.
  task automatic step(input logic v, input logic h, input logic c);
    @(posedge clk);
    #1;
    vs    = v;
    href  = h;
    clken = c;
    @(negedge clk);
    mon(1'b0, b0.post_clken, b0.post_data, b0.frame_done);
    mon(1'b1, b1.post_clken, b1.post_data, b1.frame_done);
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= lat_of(); k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("post_vsync", 32'(post_vsync_s()), 32'(k == lat_of()));
    end
  endtask

  task automatic send_line(input int r, input int n, input logic gaps, input logic live);
    for (int c = 0; c < n; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (live) begin
        q.push_back('{dut: sel, cyc: cyc + lat_of(), data: exp_pix(r, c)});
        last_acc = cyc;
      end else begin
        check("post_clken_idle", 32'(post_clken_s()), 32'(0));
      end
      check("sort_en", 32'(sort_en_s()), 32'(live));
      if (gaps) step(1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic finish_frame(input int n);
    repeat (lat_of() + 4) step(1'b0, 1'b0, 1'b0);
    exp_done[sel]++;
    check("frame_done_count", done_cnt[sel], exp_done[sel]);
    check("frame_done_cycle", done_cyc[sel], last_acc + lat_of() + 1);
    check("post_clken_count", pulse_cnt[sel] - pulse_base[sel], n);
    check("pending_pixels", q.size(), 0);
    check("sort_en_after", 32'(sort_en_s()), 32'(0));
    pulse_base[sel] = pulse_cnt[sel];
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("rst_sort_en",    32'(b0.sort_en),    32'(0));
    check("rst_post_clken", 32'(b0.post_clken), 32'(0));
    check("rst_post_data",  32'(b0.post_data),  32'(0));
    check("rst_frame_done", 32'(b0.frame_done), 32'(0));
    check("rst_line_err",   32'(b0.line_err),   32'(0));
    check("rst_frame_err",  32'(b0.frame_err),  32'(0));
    check("rst_sort_en_1",  32'(b1.sort_en),    32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // 1: continuous frame
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(r, 4, 1'b0, 1'b1);
    finish_frame(12);
    check("t1_line_err",  32'(line_err_s()),  32'(0));
    check("t1_frame_err", 32'(frame_err_s()), 32'(0));

    // 2: clken gaps inside href
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(r, 4, 1'b1, 1'b1);
    finish_frame(12);

    // 3: line 1 cut to three pixels
    vsync_pulse();
    send_line(0, 4, 1'b0, 1'b1);
    send_line(1, 3, 1'b0, 1'b1);
    check("t3_line_err_set", 32'(line_err_s()), 32'(1));
    send_line(2, 4, 1'b0, 1'b1);
    finish_frame(11);
    check("t3_line_err_held", 32'(line_err_s()), 32'(1));

    // 4: vsync restart after row 1
    vsync_pulse();
    check("t4_line_err_clr", 32'(line_err_s()), 32'(0));
    send_line(0, 4, 1'b0, 1'b1);
    send_line(1, 4, 1'b0, 1'b1);
    check("t4_frame_err_pre", 32'(frame_err_s()), 32'(0));
    vsync_pulse();
    check("t4_frame_err_set", 32'(frame_err_s()), 32'(1));
    for (int r = 0; r < 3; r++) send_line(r, 4, 1'b0, 1'b1);
    finish_frame(20);
    check("t4_frame_err_held", 32'(frame_err_s()), 32'(1));

    // 5: reset mid-line
    vsync_pulse();
    check("t5_frame_err_clr", 32'(frame_err_s()), 32'(0));
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("t5_sort_en",    32'(b0.sort_en),    32'(0));
    check("t5_post_clken", 32'(b0.post_clken), 32'(0));
    check("t5_post_data",  32'(b0.post_data),  32'(0));
    check("t5_post_href",  32'(b0.post_href),  32'(0));
    check("t5_frame_done", 32'(b0.frame_done), 32'(0));
    step(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_line(0, 4, 1'b0, 1'b0);
    send_line(1, 4, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("t5_no_output", pulse_cnt[0] - pulse_base[0], 0);
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(r, 4, 1'b0, 1'b1);
    finish_frame(12);

    // 6: LAT=1, 3x3 instance
    sel = 1'b1;
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(r, 3, 1'b0, 1'b1);
    finish_frame(9);
    check("t6_line_err", 32'(line_err_s()), 32'(0));
    check("t6_dut0_quiet", 32'(b0.sort_en), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
